// File: rtl/line_feed_pkg.sv
// Shared definitions for the line feed controller: default geometry and FSM states.
// Default parameter values live here so the top and any wrappers agree on them.
package line_feed_pkg;

   localparam int unsigned DEF_LINE_W      = 512;
   localparam int unsigned DEF_IMG_H       = 512;
   localparam int unsigned DEF_PRIME_LINES = 4;
   localparam int unsigned DEF_DUMMY_LINES = 2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRIME     = 3'd1,
      ST_WAIT_INTR = 3'd2,
      ST_LINE      = 3'd3,
      ST_DUMMY     = 3'd4,
      ST_DONE      = 3'd5
   } line_state_e;

endpackage

// File: rtl/intr_credit.sv
// Rising-edge detector on the filter interrupt feeding a 2-bit saturating credit counter.
// Overrun is sticky until the controller clears it at the start of a new frame.
module intr_credit (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       clear_i,
   input  logic       enable_i,
   input  logic       intr_i,
   input  logic       consume_i,
   output logic [1:0] credit_o,
   output logic       overrun_o
);

   logic       intrLvl_q;
   logic [1:0] credit_q;
   logic [1:0] credit_d;
   logic       overrun_q;
   logic       overrun_d;
   logic       rise;

   // Edges are only credited while a frame is in progress; idle edges are dropped.
   assign rise = enable_i & intr_i & ~intrLvl_q;

   always_comb begin
      credit_d  = credit_q;
      overrun_d = overrun_q;
      if (clear_i) begin
         credit_d  = 2'd0;
         overrun_d = 1'b0;
      end else if (rise && !consume_i) begin
         if (credit_q == 2'd3) begin
            overrun_d = 1'b1;
         end else begin
            credit_d = credit_q + 2'd1;
         end
      end else if (!rise && consume_i && credit_q != 2'd0) begin
         credit_d = credit_q - 2'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         intrLvl_q <= 1'b0;
         credit_q  <= 2'd0;
         overrun_q <= 1'b0;
      end else begin
         intrLvl_q <= intr_i;
         credit_q  <= credit_d;
         overrun_q <= overrun_d;
      end
   end

   assign credit_o  = credit_q;
   assign overrun_o = overrun_q;

endmodule

// File: rtl/line_feed_ctrl.sv
// Feeds image lines from a streaming source to a filter slave, pacing each line after the
// first few on a "line consumed" interrupt, then appends all-zero lines to flush the filter.
module line_feed_ctrl
   import line_feed_pkg::*;
#(
   parameter int unsigned LINE_W      = DEF_LINE_W,
   parameter int unsigned IMG_H       = DEF_IMG_H,
   parameter int unsigned PRIME_LINES = DEF_PRIME_LINES,
   parameter int unsigned DUMMY_LINES = DEF_DUMMY_LINES
) (
   input  logic       axi_clk,
   input  logic       axi_reset,
   input  logic       i_start,
   input  logic       i_src_valid,
   input  logic [7:0] i_src_data,
   output logic       o_src_ready,
   output logic       o_data_valid,
   output logic [7:0] o_data,
   input  logic       i_data_ready,
   input  logic       i_intr,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_overrun
);

   // Priming never sends more source lines than the image actually has.
   localparam int unsigned PRIME_EFF   = (PRIME_LINES < IMG_H) ? PRIME_LINES : IMG_H;
   localparam int unsigned TOTAL_LINES = IMG_H + DUMMY_LINES;
   localparam int unsigned BEAT_W      = (LINE_W > 1) ? $clog2(LINE_W) : 1;
   localparam int unsigned LINE_CW     = $clog2(TOTAL_LINES + 1);

   localparam logic [BEAT_W-1:0]  LAST_BEAT   = BEAT_W'(LINE_W - 1);
   localparam logic [LINE_CW-1:0] PRIME_CNT   = LINE_CW'(PRIME_EFF);
   localparam logic [LINE_CW-1:0] SRC_CNT     = LINE_CW'(IMG_H);
   localparam logic [LINE_CW-1:0] TOTAL_CNT   = LINE_CW'(TOTAL_LINES);

   line_state_e        state_q;
   line_state_e        state_d;
   logic [BEAT_W-1:0]  beat_q;
   logic [BEAT_W-1:0]  beat_d;
   logic [LINE_CW-1:0] line_q;
   logic [LINE_CW-1:0] line_d;
   logic [LINE_CW-1:0] lineNext;
   logic [1:0]         credit;
   logic               beat;
   logic               lineEnd;
   logic               consume;
   logic               startAcc;

   always_comb begin
      o_data_valid = 1'b0;
      o_data       = 8'd0;
      o_src_ready  = 1'b0;
      case (state_q)
         ST_PRIME, ST_LINE: begin
            o_data_valid = i_src_valid;
            o_data       = i_src_data;
            o_src_ready  = i_data_ready;
         end
         ST_DUMMY: begin
            o_data_valid = 1'b1;
         end
         default: begin
            o_data_valid = 1'b0;
         end
      endcase
   end

   assign beat     = o_data_valid & i_data_ready;
   assign lineEnd  = beat && (beat_q == LAST_BEAT);
   assign lineNext = line_q + LINE_CW'(1);

   // Beat and line counters advance on any beat; the FSM only decides where to go next.
   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      line_d   = line_q;
      consume  = 1'b0;
      startAcc = 1'b0;
      if (beat) begin
         beat_d = lineEnd ? '0 : beat_q + BEAT_W'(1);
      end
      if (lineEnd) begin
         line_d = lineNext;
      end
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               startAcc = 1'b1;
               beat_d   = '0;
               line_d   = '0;
               state_d  = (PRIME_EFF == 0) ? ST_WAIT_INTR : ST_PRIME;
            end
         end
         ST_PRIME: begin
            if (lineEnd && lineNext == PRIME_CNT) begin
               state_d = (lineNext < TOTAL_CNT) ? ST_WAIT_INTR : ST_DONE;
            end
         end
         ST_WAIT_INTR: begin
            if (credit != 2'd0) begin
               consume = 1'b1;
               state_d = (line_q < SRC_CNT) ? ST_LINE : ST_DUMMY;
            end
         end
         ST_LINE, ST_DUMMY: begin
            if (lineEnd) begin
               state_d = (lineNext == TOTAL_CNT) ? ST_DONE : ST_WAIT_INTR;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         line_q  <= line_d;
      end
   end

   intr_credit u_credit (
      .clk_i     (axi_clk),
      .reset_i   (axi_reset),
      .clear_i   (startAcc),
      .enable_i  (state_q != ST_IDLE),
      .intr_i    (i_intr),
      .consume_i (consume),
      .credit_o  (credit),
      .overrun_o (o_overrun)
   );

   assign o_busy = (state_q != ST_IDLE);
   assign o_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_line_feed_ctrl.sv
// Randomized bench for line_feed_ctrl: the model views the output as one ordered stream
// (image pixels, then zeros) gated by how many lines the priming and interrupts unlock.
module tb_line_feed_ctrl;

   localparam int LINE_W      = 4;
   localparam int IMG_H       = 6;
   localparam int PRIME_LINES = 4;
   localparam int DUMMY_LINES = 2;
   localparam int PRIME_EFF   = (PRIME_LINES < IMG_H) ? PRIME_LINES : IMG_H;
   localparam int SRC_BEATS   = IMG_H * LINE_W;
   localparam int TOTAL_BEATS = (IMG_H + DUMMY_LINES) * LINE_W;

   logic       axi_clk = 1'b0;
   logic       axi_reset;
   logic       i_start;
   logic       i_src_valid;
   logic [7:0] i_src_data;
   logic       o_src_ready;
   logic       o_data_valid;
   logic [7:0] o_data;
   logic       i_data_ready;
   logic       i_intr;
   logic       o_busy;
   logic       o_done;
   logic       o_overrun;

   int         compared;
   int         mismatched;
   int         beatIdx;
   int         srcIdx;
   int         granted;
   int         doneCount;
   logic       overrunExp;
   bit         modelBusy;
   logic       intrLvl;
   logic [7:0] pix [SRC_BEATS];

   line_feed_ctrl #(
      .LINE_W      (LINE_W),
      .IMG_H       (IMG_H),
      .PRIME_LINES (PRIME_LINES),
      .DUMMY_LINES (DUMMY_LINES)
   ) dut (
      .axi_clk      (axi_clk),
      .axi_reset    (axi_reset),
      .i_start      (i_start),
      .i_src_valid  (i_src_valid),
      .i_src_data   (i_src_data),
      .o_src_ready  (o_src_ready),
      .o_data_valid (o_data_valid),
      .o_data       (o_data),
      .i_data_ready (i_data_ready),
      .i_intr       (i_intr),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_overrun    (o_overrun)
   );

   always #5 axi_clk = ~axi_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h (beat %0d)", tag, observed, expected, beatIdx);
      end
   endtask

   task automatic modelStart();
      beatIdx    = 0;
      srcIdx     = 0;
      granted    = 0;
      doneCount  = 0;
      overrunExp = 1'b0;
      modelBusy  = 1'b1;
      for (int i = 0; i < SRC_BEATS; i++) pix[i] = 8'($urandom);
   endtask

   // Drive one cycle at the falling edge, then judge what the coming rising edge will accept.
   task automatic applyStimulus(input logic v, input logic r, input logic st, input logic rst);
      @(negedge axi_clk);
      i_src_valid  = v;
      i_data_ready = r;
      i_start      = st;
      axi_reset    = rst;
      i_intr       = intrLvl;
      i_src_data   = (v && srcIdx < SRC_BEATS) ? pix[srcIdx] : 8'($urandom);
      #1;
      if (o_data_valid) begin
         if (beatIdx < SRC_BEATS) checkOutput("srcReadyMirror", o_src_ready, i_data_ready);
         else checkOutput("dummySrcReady", o_src_ready, 0);
      end
      if (o_data_valid && i_data_ready) begin
         checkOutput("beatAllowed", beatIdx < (PRIME_EFF + granted) * LINE_W, 1);
         checkOutput("pixel", o_data, (beatIdx < SRC_BEATS) ? pix[beatIdx] : 8'd0);
         beatIdx++;
      end
      if (i_src_valid && o_src_ready) srcIdx++;
      if (o_done) doneCount++;
   endtask

   task automatic randStep();
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0, 1'b0);
   endtask

   task automatic step(input bit srcOn);
      if (srcOn) randStep();
      else applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   // A credit beyond three outstanding is lost and flags overrun.
   task automatic pulseIntr(input bit srcOn);
      int started;
      int bank;
      if (modelBusy) begin
         started = (beatIdx + LINE_W - 1) / LINE_W;
         bank    = granted - ((started > PRIME_EFF) ? started - PRIME_EFF : 0);
         if (bank >= 3) overrunExp = 1'b1;
         else granted++;
      end
      intrLvl = 1'b1;
      step(srcOn);
      step(srcOn);
      intrLvl = 1'b0;
      step(srcOn);
      step(srcOn);
   endtask

   task automatic runUntilBeats(input int target, input int budget, input bit fullSpeed);
      int n;
      n = 0;
      while (beatIdx < target && n < budget) begin
         if (fullSpeed) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
         else randStep();
         n++;
      end
      checkOutput("reachBeats", beatIdx, target);
   endtask

   task automatic quietCheck(input int n);
      repeat (n) randStep();
      checkOutput("waitNoValid", o_data_valid, 0);
      checkOutput("waitBusy", o_busy, 1);
   endtask

   task automatic finishCheck();
      repeat (4) randStep();
      checkOutput("donePulses", doneCount, 1);
      checkOutput("idleBusy", o_busy, 0);
      checkOutput("overrunSticky", o_overrun, overrunExp);
      modelBusy = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      compared     = 0;
      mismatched   = 0;
      intrLvl      = 1'b0;
      modelBusy    = 1'b0;
      axi_reset    = 1'b1;
      i_start      = 1'b0;
      i_src_valid  = 1'b0;
      i_src_data   = 8'd0;
      i_data_ready = 1'b0;
      i_intr       = 1'b0;
      modelStart();
      modelBusy = 1'b0;

      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("rstBusy", o_busy, 0);
      checkOutput("rstDone", o_done, 0);
      checkOutput("rstValid", o_data_valid, 0);
      checkOutput("rstSrcReady", o_src_ready, 0);
      checkOutput("rstOverrun", o_overrun, 0);

      pulseIntr(1'b1);
      pulseIntr(1'b1);
      checkOutput("idleIgnoresIntr", o_busy, 0);

      // Full-speed priming, then one line per interrupt, dummies last.
      modelStart();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      runUntilBeats(PRIME_EFF * LINE_W, PRIME_EFF * LINE_W, 1'b1);
      quietCheck(10);
      checkOutput("noOverrun", o_overrun, 0);
      for (int k = 0; k < IMG_H + DUMMY_LINES - PRIME_EFF; k++) begin
         pulseIntr(1'b1);
         runUntilBeats((PRIME_EFF + k + 1) * LINE_W, 200, 1'b0);
         if (k < IMG_H + DUMMY_LINES - PRIME_EFF - 1) quietCheck(10);
      end
      finishCheck();

      // Four edges while priming is stalled saturate the credit counter.
      modelStart();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      repeat (4) pulseIntr(1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("overrunSet", o_overrun, overrunExp);
      runUntilBeats((PRIME_EFF + 3) * LINE_W, 400, 1'b0);
      quietCheck(10);
      pulseIntr(1'b1);
      runUntilBeats(TOTAL_BEATS, 200, 1'b0);
      finishCheck();

      // Restart clears overrun; a start while busy is ignored; reset mid-line wins over start.
      modelStart();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("overrunCleared", o_overrun, 0);
      runUntilBeats(PRIME_EFF * LINE_W, 200, 1'b0);
      quietCheck(5);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      quietCheck(10);
      pulseIntr(1'b0);
      runUntilBeats(PRIME_EFF * LINE_W + 2, 200, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      modelBusy = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("midResetBusy", o_busy, 0);
      checkOutput("midResetValid", o_data_valid, 0);
      checkOutput("midResetDone", o_done, 0);
      checkOutput("midResetOverrun", o_overrun, 0);
      repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("resetBeatsStart", o_busy, 0);

      modelStart();
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      runUntilBeats(PRIME_EFF * LINE_W, PRIME_EFF * LINE_W, 1'b1);
      quietCheck(10);
      for (int k = 0; k < IMG_H + DUMMY_LINES - PRIME_EFF; k++) begin
         pulseIntr(1'b1);
         runUntilBeats((PRIME_EFF + k + 1) * LINE_W, 200, 1'b0);
      end
      finishCheck();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/line_feed_ctrl.md
LINE_FEED_CTRL -- requirements
Module: line_feed_ctrl

Interface
REQ-001 SHALL have parameter LINE_W, default 512, meaning pixels per image line.
REQ-002 SHALL have parameter IMG_H, default 512, meaning image lines taken from the source.
REQ-003 SHALL have parameter PRIME_LINES, default 4, meaning lines sent back-to-back after start with no interrupt wait.
REQ-004 SHALL have parameter DUMMY_LINES, default 2, meaning all-zero lines appended after the image.
REQ-005 SHALL have port axi_clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port axi_reset  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port i_start  input  1  one-cycle start pulse, honoured only in IDLE.
REQ-008 SHALL have port i_src_valid  input  1  source pixel valid.
REQ-009 SHALL have port i_src_data  input  8  source pixel.
REQ-010 SHALL have port o_src_ready  output  1  source pixel accepted when high with i_src_valid.
REQ-011 SHALL have port o_data_valid  output  1  pixel valid toward the filter slave.
REQ-012 SHALL have port o_data  output  8  pixel toward the filter slave.
REQ-013 SHALL have port i_data_ready  input  1  filter slave ready.
REQ-014 SHALL have port i_intr  input  1  filter "line consumed" interrupt, level signal, edge-detected.
REQ-015 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port o_done  output  1  one-cycle pulse after the final dummy beat.
REQ-017 SHALL have port o_overrun  output  1  sticky; interrupt credit saturated.

Function
REQ-018 SHALL implement states IDLE, PRIME, WAIT_INTR, LINE, DUMMY, DONE.
REQ-019 SHALL define a beat as o_data_valid & i_data_ready in the same cycle.
REQ-020 SHALL in PRIME/LINE drive o_data_valid=i_src_valid, o_data=i_src_data, o_src_ready=i_data_ready, combinationally, with zero latency.
REQ-021 SHALL in DUMMY drive o_data_valid=1, o_data=0, o_src_ready=0; in all other states o_data_valid=0, o_src_ready=0, o_data=0.
REQ-022 SHALL go IDLE->PRIME on i_start; i_start in any other state is ignored.
REQ-023 SHALL count beats per line (wrap at LINE_W-1 to 0) and completed lines.
REQ-024 SHALL leave PRIME after PRIME_LINES*LINE_W beats; go to WAIT_INTR if lines remain, else DONE.
REQ-025 SHALL in WAIT_INTR consume one credit and go to LINE while source lines remain (< IMG_H), else to DUMMY; stay if credit is zero.
REQ-026 SHALL leave LINE/DUMMY after LINE_W beats, returning to WAIT_INTR, or to DONE after the last of IMG_H+DUMMY_LINES lines.
REQ-027 SHALL hold DONE for one cycle with o_done=1, then return to IDLE.
REQ-028 SHALL register i_intr and add one credit per 0->1 transition, in any state other than IDLE.
REQ-029 SHALL hold credits in a 2-bit counter; a simultaneous increment and consume leaves it unchanged; an increment at 3 keeps 3 and sets o_overrun.
REQ-030 SHALL clear credits and o_overrun on i_start; rising edges seen in IDLE are discarded.
REQ-031 SHALL, when PRIME_LINES >= IMG_H, send only IMG_H source lines in PRIME before dummy handling.

Reset
REQ-032 SHALL on axi_reset force IDLE, clear counters, credits, the i_intr register and o_overrun, with o_busy=o_done=0, even mid-line.
REQ-033 SHALL let axi_reset override i_start in the same cycle.

Structure
REQ-034 SHALL place the state enum and the default parameter constants in package line_feed_pkg.
REQ-035 SHALL implement the edge detector and saturating credit counter as sub-module intr_credit.

Verification (LINE_W=4, IMG_H=6, PRIME_LINES=4, DUMMY_LINES=2)
REQ-036 SHALL cover: start, src always valid, ready=1 -> 16 source beats back-to-back, then o_data_valid=0 in WAIT_INTR.
REQ-037 SHALL cover: 4 intr pulses spaced 10 cycles -> 4 source beats, 4 source beats, 4 zero beats, 4 zero beats, then one o_done pulse, o_busy=0.
REQ-038 SHALL cover: i_data_ready toggled 1/0 during LINE -> no pixel dropped or duplicated; o_src_ready mirrors ready.
REQ-039 SHALL cover: 4 intr edges during PRIME -> credits=3, o_overrun=1, then 3 lines sent with no further wait.
REQ-040 SHALL cover: axi_reset asserted at beat 2 of a LINE -> next cycle IDLE, o_valid=0, credits=0; a new start replays from PRIME.
